// File: rtl/biquad_coef_loader.sv
// Framed coefficient loader for one bi-quad section: receives SYNC + 5 coefficients + XOR checksum,
// holds a validated set in a shadow bank and commits it atomically on a filter sample strobe.
module biquad_coef_loader #(
    parameter logic [7:0]  SYNC      = 8'hA5,
    parameter logic [7:0]  RESET_B10 = 8'h7F,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic [7:0] din,
    input  logic       din_valid,
    output logic       din_ready,
    input  logic       svalid,
    output logic [7:0] b10,
    output logic [7:0] b11,
    output logic [7:0] b12,
    output logic [7:0] a11,
    output logic [7:0] a12,
    output logic       pending,
    output logic       commit,
    output logic       csum_err,
    output logic       tout_err,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        ST_HUNT = 2'd0,
        ST_LOAD = 2'd1,
        ST_CSUM = 2'd2,
        ST_PEND = 2'd3
    } state_t;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [2:0]  r_idx;
    logic [7:0]  r_acc;
    logic [15:0] r_idle;
    logic [7:0]  r_sh_b10, r_sh_b11, r_sh_b12, r_sh_a11, r_sh_a12;
    logic [7:0]  r_b10, r_b11, r_b12, r_a11, r_a12;
    logic        r_commit, r_csum_err, r_tout_err;

    logic        w_accept;
    logic        w_counting;
    logic        w_timeout;
    logic        w_cs_ok;
    logic        w_sync_hit;
    logic        w_do_commit;

    // Handshake: a byte transfers on a rising edge where din_valid && din_ready; din_ready depends
    // only on the state register, never on din_valid, so the source may hold a byte until taken.
    assign w_accept    = din_valid && din_ready;
    assign w_counting  = (r_state == ST_LOAD) || (r_state == ST_CSUM);
    // An accepted byte always beats a timeout landing on the same edge.
    assign w_timeout   = w_counting && !w_accept && (r_idle == TMO_LAST);
    assign w_cs_ok     = ((r_acc ^ din) == 8'h00);
    assign w_sync_hit  = (r_state == ST_HUNT) && w_accept && (din == SYNC);
    assign w_do_commit = (r_state == ST_PEND) && svalid;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state <= ST_HUNT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_HUNT: if (w_sync_hit) w_state_nxt = ST_LOAD;
            ST_LOAD: begin
                if (w_timeout)                         w_state_nxt = ST_HUNT;
                else if (w_accept && r_idx == 3'd4)    w_state_nxt = ST_CSUM;
            end
            ST_CSUM: begin
                if (w_timeout)                         w_state_nxt = ST_HUNT;
                else if (w_accept)                     w_state_nxt = w_cs_ok ? ST_PEND : ST_HUNT;
            end
            ST_PEND: if (svalid) w_state_nxt = ST_HUNT;
            default:                                   w_state_nxt = ST_HUNT;
        endcase
    end

    always_comb begin
        din_ready = (r_state != ST_PEND);
        pending   = (r_state == ST_PEND);
        dbg_state = r_state;
        b10       = r_b10;
        b11       = r_b11;
        b12       = r_b12;
        a11       = r_a11;
        a12       = r_a12;
        commit    = r_commit;
        csum_err  = r_csum_err;
        tout_err  = r_tout_err;
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_idx      <= 3'd0;
            r_acc      <= 8'h00;
            r_idle     <= 16'd0;
            r_sh_b10   <= 8'h00;
            r_sh_b11   <= 8'h00;
            r_sh_b12   <= 8'h00;
            r_sh_a11   <= 8'h00;
            r_sh_a12   <= 8'h00;
            r_b10      <= RESET_B10;
            r_b11      <= 8'h00;
            r_b12      <= 8'h00;
            r_a11      <= 8'h00;
            r_a12      <= 8'h00;
            r_commit   <= 1'b0;
            r_csum_err <= 1'b0;
            r_tout_err <= 1'b0;
        end else begin
            r_commit   <= w_do_commit;
            r_csum_err <= (r_state == ST_CSUM) && w_accept && !w_cs_ok;
            r_tout_err <= w_timeout;
            r_idle     <= (w_counting && !w_accept && !w_timeout) ? r_idle + 16'd1 : 16'd0;

            if (w_sync_hit) begin
                r_idx <= 3'd0;
                r_acc <= SYNC;
            end

            if (r_state == ST_LOAD && w_accept) begin
                r_acc <= r_acc ^ din;
                if (r_idx != 3'd4) r_idx <= r_idx + 3'd1;
                case (r_idx)
                    3'd0:    r_sh_b10 <= din;
                    3'd1:    r_sh_b11 <= din;
                    3'd2:    r_sh_b12 <= din;
                    3'd3:    r_sh_a11 <= din;
                    3'd4:    r_sh_a12 <= din;
                    default: ;
                endcase
            end

            // All five actives move together on the sample edge, so no sample sees a mixed set.
            if (w_do_commit) begin
                r_b10 <= r_sh_b10;
                r_b11 <= r_sh_b11;
                r_b12 <= r_sh_b12;
                r_a11 <= r_sh_a11;
                r_a12 <= r_sh_a12;
            end
        end
    end

endmodule

// File: tb/tb_biquad_coef_loader.sv
// Bench for biquad_coef_loader: directed plan steps plus random frames checked against a
// frame-level model (expected-set queue and pulse counters).
module tb_biquad_coef_loader;

    localparam logic [7:0]  SYNC  = 8'hA5;
    localparam logic [39:0] RST_C = 40'h7F_00_00_00_00;

    logic       clk = 1'b0;
    logic       nreset = 1'b0;
    logic [7:0] din = 8'h00;
    logic       din_valid = 1'b0;
    logic       svalid = 1'b0;
    logic       din_ready, pending, commit, csum_err, tout_err;
    logic [7:0] b10, b11, b12, a11, a12;
    logic [1:0] dbg_state;

    biquad_coef_loader #(.SYNC(SYNC), .RESET_B10(8'h7F), .TIMEOUT(8)) dut (
        .clk(clk), .nreset(nreset), .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .svalid(svalid), .b10(b10), .b11(b11), .b12(b12), .a11(a11), .a12(a12),
        .pending(pending), .commit(commit), .csum_err(csum_err), .tout_err(tout_err),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err = 0;
    int n_commit = 0, n_csum = 0, n_tout = 0;
    int exp_commit = 0, exp_csum = 0, exp_tout = 0;
    logic [39:0] act = RST_C;
    logic [39:0] exp_q[$];
    logic [39:0] coefs;

    assign coefs = {b10, b11, b12, a11, a12};

    always @(posedge clk) begin
        #1;
        if (commit)   n_commit++;
        if (csum_err) n_csum++;
        if (tout_err) n_tout++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] xsum(input logic [39:0] c);
        return SYNC ^ c[39:32] ^ c[31:24] ^ c[23:16] ^ c[15:8] ^ c[7:0];
    endfunction

    task automatic chk_reset(input string tag);
        chk({tag, "_coefs"}, coefs, RST_C);
        chk({tag, "_pending"}, 40'(pending), 40'd0);
        chk({tag, "_commit"}, 40'(commit), 40'd0);
        chk({tag, "_csum_err"}, 40'(csum_err), 40'd0);
        chk({tag, "_tout_err"}, 40'(tout_err), 40'd0);
        chk({tag, "_ready"}, 40'(din_ready), 40'd1);
        chk({tag, "_state"}, 40'(dbg_state), 40'd0);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, input bit rnd_sv);
        repeat (gap) begin
            din       = 8'($urandom);
            din_valid = 1'b0;
            svalid    = rnd_sv ? 1'($urandom_range(0, 1)) : 1'b0;
            tick();
        end
        din       = b;
        din_valid = 1'b1;
        svalid    = rnd_sv ? 1'($urandom_range(0, 1)) : 1'b0;
        tick();
        din_valid = 1'b0;
        svalid    = 1'b0;
    endtask

    task automatic post_frame(input string tag, input logic [39:0] c, input logic [7:0] cs);
        if (cs == xsum(c)) begin
            exp_q.push_back(c);
            chk({tag, "_pending"}, 40'(pending), 40'd1);
            chk({tag, "_ready"}, 40'(din_ready), 40'd0);
        end else begin
            exp_csum++;
            chk({tag, "_csum_err"}, 40'(csum_err), 40'd1);
            chk({tag, "_pending"}, 40'(pending), 40'd0);
        end
        chk({tag, "_coefs_held"}, coefs, act);
        chk({tag, "_n_csum"}, 40'(n_csum), 40'(exp_csum));
        chk({tag, "_n_commit"}, 40'(n_commit), 40'(exp_commit));
    endtask

    task automatic send_body(input string tag, input logic [39:0] c, input logic [7:0] cs,
                             input int maxgap, input bit rnd_sv);
        for (int k = 0; k < 5; k++) send_byte(c[39-8*k -: 8], $urandom_range(0, maxgap), rnd_sv);
        send_byte(cs, $urandom_range(0, maxgap), rnd_sv);
        post_frame(tag, c, cs);
    endtask

    task automatic send_frame(input string tag, input logic [39:0] c, input logic [7:0] cs,
                              input int maxgap, input bit rnd_sv);
        send_byte(SYNC, $urandom_range(0, maxgap), rnd_sv);
        send_body(tag, c, cs, maxgap, rnd_sv);
    endtask

    task automatic do_commit(input string tag, input int wait_cycles);
        repeat (wait_cycles) tick();
        chk({tag, "_pend_wait"}, 40'(pending), 40'd1);
        chk({tag, "_coefs_wait"}, coefs, act);
        svalid = 1'b1;
        tick();
        svalid = 1'b0;
        if (exp_q.size() > 0) act = exp_q.pop_front();
        exp_commit++;
        chk({tag, "_commit"}, 40'(commit), 40'd1);
        chk({tag, "_coefs"}, coefs, act);
        chk({tag, "_pending_clr"}, 40'(pending), 40'd0);
        chk({tag, "_ready"}, 40'(din_ready), 40'd1);
        tick();
        chk({tag, "_commit_once"}, 40'(commit), 40'd0);
        chk({tag, "_n_commit"}, 40'(n_commit), 40'(exp_commit));
    endtask

    task automatic async_reset(input string tag);
        #2 nreset = 1'b0;
        #1;
        act = RST_C;
        exp_q.delete();
        chk_reset(tag);
        @(negedge clk);
        nreset = 1'b1;
        tick();
        chk({tag, "_state_rel"}, 40'(dbg_state), 40'd0);
        chk({tag, "_pend_rel"}, 40'(pending), 40'd0);
    endtask

    initial begin
        logic [39:0] c;
        logic [7:0]  cs;
        logic [7:0]  g;
        bit          good;

        // Reset state
        nreset = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset("rst");
        nreset = 1'b1;
        tick();
        chk_reset("rst_rel");

        // Bad checksum from reset, then good frame with svalid low, then commit
        send_frame("bad_cs", 40'h40_00_C0_10_05, 8'h31, 0, 1'b0);
        tick();
        chk("bad_cs_pulse_once", 40'(csum_err), 40'd0);
        chk("bad_cs_coefs", coefs, RST_C);
        send_frame("good_a", 40'h40_00_C0_10_05, 8'h30, 0, 1'b0);
        do_commit("good_a", 3);
        chk("good_a_value", coefs, 40'h40_00_C0_10_05);

        // Garbage before SYNC, SYNC-valued coefficient
        send_byte(8'h00, 0, 1'b0);
        send_byte(8'hFF, 0, 1'b0);
        send_byte(8'h12, 0, 1'b0);
        send_frame("sync_data", 40'hA5_01_02_03_04, 8'h04, 0, 1'b0);
        do_commit("sync_data", 0);
        chk("sync_data_no_csum", 40'(n_csum), 40'(exp_csum));
        chk("sync_data_no_tout", 40'(n_tout), 40'(exp_tout));

        // Timeout after 8 idle cycles
        send_byte(SYNC, 0, 1'b0);
        send_byte(8'h11, 0, 1'b0);
        send_byte(8'h22, 0, 1'b0);
        repeat (7) tick();
        chk("tmo_not_yet", 40'(tout_err), 40'd0);
        chk("tmo_still_load", 40'(dbg_state), 40'd1);
        tick();
        exp_tout++;
        chk("tmo_pulse", 40'(tout_err), 40'd1);
        chk("tmo_hunt", 40'(dbg_state), 40'd0);
        chk("tmo_n", 40'(n_tout), 40'(exp_tout));
        chk("tmo_coefs", coefs, act);
        send_frame("after_tmo", 40'h12_34_56_78_9A, xsum(40'h12_34_56_78_9A), 0, 1'b0);
        do_commit("after_tmo", 1);

        // Seven-cycle gap is tolerated
        c = 40'h11_22_33_44_55;
        send_byte(SYNC, 0, 1'b0);
        send_byte(8'h11, 0, 1'b0);
        send_byte(8'h22, 0, 1'b0);
        send_byte(8'h33, 7, 1'b0);
        send_byte(8'h44, 0, 1'b0);
        send_byte(8'h55, 0, 1'b0);
        send_byte(xsum(c), 0, 1'b0);
        post_frame("gap7", c, xsum(c));
        chk("gap7_no_tout", 40'(n_tout), 40'(exp_tout));
        do_commit("gap7", 2);

        // Checksum edge coincides with svalid; next SYNC held during PEND
        c  = 40'hC1_02_83_04_85;
        cs = xsum(c);
        send_byte(SYNC, 0, 1'b0);
        for (int k = 0; k < 5; k++) send_byte(c[39-8*k -: 8], 0, 1'b0);
        din = cs; din_valid = 1'b1; svalid = 1'b1;
        tick();
        svalid = 1'b0;
        din    = SYNC;
        exp_q.push_back(c);
        chk("simul_no_commit", 40'(commit), 40'd0);
        chk("simul_pending", 40'(pending), 40'd1);
        chk("simul_ready", 40'(din_ready), 40'd0);
        tick();
        tick();
        chk("pend_hold_ready", 40'(din_ready), 40'd0);
        chk("pend_hold_coefs", coefs, act);
        svalid = 1'b1;
        tick();
        svalid = 1'b0;
        act = exp_q.pop_front();
        exp_commit++;
        chk("pend_commit", 40'(commit), 40'd1);
        chk("pend_coefs", coefs, act);
        chk("pend_ready_after", 40'(din_ready), 40'd1);
        tick();
        din_valid = 1'b0;
        chk("b2b_sync_taken", 40'(dbg_state), 40'd1);
        c = 40'h0F_1E_2D_3C_4B;
        send_body("b2b", c, xsum(c), 2, 1'b0);
        do_commit("b2b", 0);

        // Reset while in LOAD
        send_byte(SYNC, 0, 1'b0);
        send_byte(8'h12, 0, 1'b0);
        async_reset("rst_load");

        // Reset while in PEND, after a commit moved coefficients away from reset
        c = 40'h22_33_44_55_66;
        send_frame("pre_rst", c, xsum(c), 0, 1'b0);
        do_commit("pre_rst", 0);
        c = 40'h77_66_55_44_33;
        send_frame("pend_rst", c, xsum(c), 0, 1'b0);
        async_reset("rst_pend");
        c = 40'h01_80_7F_FF_10;
        send_frame("post_rst", c, xsum(c), 0, 1'b0);
        do_commit("post_rst", 0);

        // Randomised frames with garbage, gaps, stray svalid and corrupted checksums
        for (int f = 0; f < 24; f++) begin
            for (int gb = 0; gb < int'($urandom_range(0, 2)); gb++) begin
                g = 8'($urandom);
                if (g == SYNC) g = 8'h00;
                send_byte(g, $urandom_range(0, 3), 1'b1);
            end
            c    = {8'($urandom), 32'($urandom)};
            good = ($urandom_range(0, 3) != 0);
            cs   = good ? xsum(c) : (xsum(c) ^ 8'($urandom_range(1, 255)));
            send_frame("rnd", c, cs, 6, 1'b1);
            if (good) do_commit("rnd", $urandom_range(0, 3));
            else tick();
        end
        chk("final_n_csum", 40'(n_csum), 40'(exp_csum));
        chk("final_n_tout", 40'(n_tout), 40'(exp_tout));
        chk("final_n_commit", 40'(n_commit), 40'(exp_commit));
        chk("final_coefs", coefs, act);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
